// File: rtl/config_table_loader.sv
// Assembles two-beat configuration entries (control beat, immediate beat) from a
// 512-bit stream into 1024-bit table rows and issues one write strobe per row.
module config_table_loader #(
   parameter int phit_size    = 512,
   parameter int dwidth_RFadd = 4,
   parameter int depth_RF     = 16,
   parameter int ctrl_width   = 21
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      load_start,
   input  logic [dwidth_RFadd-1:0]   load_base,
   input  logic [dwidth_RFadd:0]     load_count,
   input  logic [phit_size-1:0]      s_axis_tdata,
   input  logic                      s_axis_tvalid,
   input  logic                      s_axis_tlast,
   output logic                      s_axis_tready,
   output logic                      wr_en,
   output logic [dwidth_RFadd-1:0]   wr_add,
   output logic [2*phit_size-1:0]    wr_data,
   output logic                      busy,
   output logic                      done,
   output logic                      err,
   output logic [dwidth_RFadd:0]     entries_written
);

   localparam int aw = dwidth_RFadd;
   localparam logic [aw:0] max_count = (aw+1)'(depth_RF);
   localparam logic [aw:0] one       = (aw+1)'(1);

   typedef enum logic [1:0] {IDLE, CTRL, IMM, FLUSH} state_t;

   state_t                state;
   logic [aw-1:0]         base_q;
   logic [aw:0]           count_q;
   logic [ctrl_width-1:0] ctrl_q;
   logic                  hs;
   logic                  last_entry;

   assign hs         = s_axis_tvalid & s_axis_tready;
   // entries_written doubles as the index of the entry being assembled
   assign last_entry = (entries_written == count_q - one);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= IDLE;
         base_q          <= '0;
         count_q         <= '0;
         ctrl_q          <= '0;
         s_axis_tready   <= 1'b0;
         wr_en           <= 1'b0;
         wr_add          <= '0;
         wr_data         <= '0;
         busy            <= 1'b0;
         done            <= 1'b0;
         err             <= 1'b0;
         entries_written <= '0;
      end else begin
         // NOTE: pulse outputs default low each cycle and are raised only where needed;
         // every state register uses <= so all branches see the pre-edge values.
         wr_en <= 1'b0;
         done  <= 1'b0;
         case (state)
            IDLE: begin
               if (load_start) begin
                  err             <= 1'b0;
                  entries_written <= '0;
                  if (load_count != '0) begin
                     base_q        <= load_base;
                     count_q       <= (load_count > max_count) ? max_count : load_count;
                     state         <= CTRL;
                     busy          <= 1'b1;
                     s_axis_tready <= 1'b1;
                  end else begin
                     done <= 1'b1;
                  end
               end
            end
            CTRL: begin
               if (hs) begin
                  ctrl_q <= s_axis_tdata[ctrl_width-1:0];
                  if (s_axis_tlast) begin
                     err           <= 1'b1;
                     state         <= FLUSH;
                     s_axis_tready <= 1'b0;
                  end else begin
                     state <= IMM;
                  end
               end
            end
            IMM: begin
               if (hs) begin
                  wr_en           <= 1'b1;
                  wr_add          <= base_q + entries_written[aw-1:0];
                  wr_data         <= {s_axis_tdata, {(phit_size-ctrl_width){1'b0}}, ctrl_q};
                  entries_written <= entries_written + one;
                  if (last_entry) begin
                     state         <= FLUSH;
                     s_axis_tready <= 1'b0;
                     if (!s_axis_tlast) err <= 1'b1;
                  end else if (s_axis_tlast) begin
                     err           <= 1'b1;
                     state         <= FLUSH;
                     s_axis_tready <= 1'b0;
                  end else begin
                     state <= CTRL;
                  end
               end
            end
            FLUSH: begin
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
